// File: rtl/mcc_vec_loader.sv
// mcc_vec_loader: fetches up to CROSSBAR_SIZE words from memory and packs them
// into one flat vector for the MCC controller's LOAD_SUB_* states.
// Optional build macro MCC_VLD_TIMEOUT_EN adds a per-word wait limit that aborts
// the load with err=1; without it err is tied low and REQ waits indefinitely.
module mcc_vec_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned CROSSBAR_SIZE  = 32,
    parameter int unsigned CNT_WIDTH      = 6,
    parameter int unsigned ADDR_STEP      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [CNT_WIDTH-1:0]                len,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                vec_valid,
    output logic [DATA_WIDTH*CROSSBAR_SIZE-1:0] vec_out,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic                                mem_en,
    input  logic                                mem_rdy,
    input  logic [DATA_WIDTH-1:0]               mem_data_in
);

    localparam int unsigned          VecWidth = DATA_WIDTH * CROSSBAR_SIZE;
    localparam logic [CNT_WIDTH-1:0] MaxLen   = CNT_WIDTH'(CROSSBAR_SIZE);
    localparam logic [ADDR_WIDTH-1:0] Step    = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [VecWidth-1:0]    vec_q, vec_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic                   timeout;

    // Oversized requests are clamped to the slot count, never wrapped.
    assign len_eff = (len > MaxLen) ? MaxLen : len;

`ifdef MCC_VLD_TIMEOUT_EN
    localparam int unsigned WaitWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [WaitWidth-1:0] wait_q, wait_d;

    // Fires on the stall cycle that brings the wait count up to the limit.
    assign timeout = (state_q == StReq) && !mem_rdy &&
                     (wait_q == WaitWidth'(TIMEOUT_CYCLES - 1));

    // Wait counter: cleared outside REQ and on every capture, counts stalls.
    always_comb begin
        wait_d = '0;
        if (state_q == StReq && !mem_rdy) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, capture and address advance.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vec_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    if (len_eff == '0) begin
                        state_d = StFin;
                    end else begin
                        len_d   = len_eff;
                        idx_d   = '0;
                        addr_d  = base_addr;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_rdy) begin
                    for (int i = 0; i < CROSSBAR_SIZE; i++) begin
                        if (idx_q == CNT_WIDTH'(i)) begin
                            vec_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_in;
                        end
                    end
                    idx_d  = idx_q + 1'b1;
                    addr_d = addr_q + Step;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = StFin;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                valid_d = !err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign mem_en    = (state_q == StReq);
    assign mem_addr  = addr_q;
    assign vec_out   = vec_q;
    assign vec_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mcc_vec_loader.sv
// Bench for mcc_vec_loader: memory model returns data=addr, checks request
// addresses against a scoreboard and packed vectors against a local model.
module tb_mcc_vec_loader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CS = 32;
    localparam int CW = 6;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [CW-1:0]    len = '0;
    logic             busy, done, err, vec_valid, mem_en;
    logic [DW*CS-1:0] vec_out;
    logic [AW-1:0]    mem_addr;
    logic             mem_rdy = 1'b0;
    logic [DW-1:0]    mem_data_in = '0;

    mcc_vec_loader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .CROSSBAR_SIZE (CS),
        .CNT_WIDTH     (CW),
        .ADDR_STEP     (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .vec_valid  (vec_valid),
        .vec_out    (vec_out),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_rdy    (mem_rdy),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_q[$];
    int            stall_max = 0;
    int            stall_left = 0;
    int            stuck_after = -1;
    int            hs_cnt = 0;
    int            en_cnt = 0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    // Memory model: decides mem_rdy for the coming edge and scoreboards requests.
    always @(negedge clk) begin : mem_model
        logic [AW-1:0] e;
        if (!rstn) begin
            mem_rdy    = 1'b0;
            prev_stall = 1'b0;
        end else if (mem_en) begin
            en_cnt++;
            if (prev_stall) begin
                n_cmp++;
                if (mem_addr !== stall_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: mem_addr=%h required %h", mem_addr, stall_addr);
                end
            end
            if (stuck_after >= 0 && hs_cnt >= stuck_after) begin
                mem_rdy = 1'b0;
            end else if (stall_left > 0) begin
                mem_rdy = 1'b0;
                stall_left--;
            end else begin
                mem_rdy    = 1'b1;
                stall_left = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
            end
            mem_data_in = mem_addr;
            if (mem_rdy) begin
                hs_cnt++;
                prev_stall = 1'b0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_addr: unexpected request at %h, none required", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e) begin
                        n_fail++;
                        $display("FAIL req_addr: mem_addr=%h required %h", mem_addr, e);
                    end
                end
            end else begin
                prev_stall = 1'b1;
                stall_addr = mem_addr;
            end
        end else begin
            // Random rdy/data while idle must be ignored by the DUT.
            mem_rdy     = 1'($urandom_range(0, 1));
            mem_data_in = $urandom;
            prev_stall  = 1'b0;
        end
    end

    function automatic logic [DW*CS-1:0] exp_vec(input logic [AW-1:0] b, input int n);
        logic [DW*CS-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*DW +: DW] = b + AW'(i * 4);
        return v;
    endfunction

    // Pulses start at the current negedge; returns at the next negedge (first REQ cycle).
    task automatic start_load(input logic [AW-1:0] b, input logic [CW-1:0] l);
        int le;
        le = (int'(l) > CS) ? CS : int'(l);
        for (int i = 0; i < le; i++) exp_q.push_back(b + AW'(i * 4));
        hs_cnt     = 0;
        en_cnt     = 0;
        stall_left = 0;
        start      = 1'b1;
        base_addr  = b;
        len        = l;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = $urandom;
        len        = CW'($urandom);
    endtask

    // lat = cycles from the start cycle to the done cycle, -1 if never seen.
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int k = 0; k <= max; k++) begin
            if (done === 1'b1) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err); end
        n_cmp++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", vec_valid); end
        n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b required 0", mem_en); end
        n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        n_cmp++; if (vec_out !== '0) begin n_fail++; $display("FAIL rst_vec_out: got nonzero required 0"); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        stall_max = 0;
        start_load(32'h100, 6'd4);
        wait_done(20, lat);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d required 5", lat); end
        n_cmp++; if (en_cnt !== 4) begin n_fail++; $display("FAIL basic_en_cycles: got %0d required 4", en_cnt); end
        @(negedge clk);
        n_cmp++; if (vec_out !== exp_vec(32'h100, 4)) begin n_fail++; $display("FAIL basic_vec: got %h required %h", vec_out[127:0], exp_vec(32'h100, 4) >> 0); end
        n_cmp++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b required 1", vec_valid); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: busy,done=%b required 00", {busy, done}); end
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_sb_empty: %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_stalls();
        int lat;
        stall_max = 3;
        start_load(32'h0, 6'd32);
        wait_done(32 * 5 + 10, lat);
        stall_max = 0;
        n_cmp++; if (lat < 33) begin n_fail++; $display("FAIL stall_done: latency %0d required >= 33", lat); end
        @(negedge clk);
        n_cmp++; if (hs_cnt !== 32) begin n_fail++; $display("FAIL stall_handshakes: got %0d required 32", hs_cnt); end
        n_cmp++; if (vec_out !== exp_vec(32'h0, 32)) begin n_fail++; $display("FAIL stall_vec: got %h required %h", vec_out[127:0], exp_vec(32'h0, 4)); end
        n_cmp++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b required 1", vec_valid); end
    endtask

    task automatic test_len_zero();
        int lat;
        start_load(32'h500, 6'd0);
        wait_done(5, lat);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d required 1", lat); end
        @(negedge clk);
        n_cmp++; if (en_cnt !== 0) begin n_fail++; $display("FAIL zero_no_mem: en cycles %0d required 0", en_cnt); end
        n_cmp++; if (vec_out !== '0) begin n_fail++; $display("FAIL zero_vec: got %h required 0", vec_out[127:0]); end
        n_cmp++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b required 1", vec_valid); end
    endtask

    task automatic test_len_clamp();
        int lat;
        start_load(32'h1000, 6'd40);
        wait_done(50, lat);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL clamp_latency: got %0d required 33", lat); end
        @(negedge clk);
        n_cmp++; if (hs_cnt !== 32) begin n_fail++; $display("FAIL clamp_handshakes: got %0d required 32", hs_cnt); end
        n_cmp++; if (en_cnt !== 32) begin n_fail++; $display("FAIL clamp_en_cycles: got %0d required 32", en_cnt); end
        n_cmp++; if (vec_out !== exp_vec(32'h1000, 32)) begin n_fail++; $display("FAIL clamp_vec: got %h required %h", vec_out[127:0], exp_vec(32'h1000, 4)); end
    endtask

    task automatic test_start_ignored();
        int lat;
        start_load(32'h200, 6'd8);
        repeat (3) @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h900;
        len       = 6'd2;
        @(negedge clk);
        start     = 1'b0;
        wait_done(20, lat);
        // Four cycles already elapsed since the original start.
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL ignore_latency: got %0d required 5", lat); end
        @(negedge clk);
        n_cmp++; if (hs_cnt !== 8) begin n_fail++; $display("FAIL ignore_handshakes: got %0d required 8", hs_cnt); end
        n_cmp++; if (vec_out !== exp_vec(32'h200, 8)) begin n_fail++; $display("FAIL ignore_vec: got %h required %h", vec_out[255:0], exp_vec(32'h200, 8) >> 0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_restarted: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_load(32'h400, 6'd32);
        for (int k = 0; k < 40 && hs_cnt < 10; k++) @(negedge clk);
        n_cmp++; if (hs_cnt !== 10) begin n_fail++; $display("FAIL midrst_reach_word10: hs %0d required 10", hs_cnt); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if ({busy, done, err, vec_valid, mem_en} !== 5'b0) begin n_fail++; $display("FAIL midrst_ctrl: busy,done,err,valid,en=%b required 00000", {busy, done, err, vec_valid, mem_en}); end
        n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL midrst_addr: got %h required 0", mem_addr); end
        n_cmp++; if (vec_out !== '0) begin n_fail++; $display("FAIL midrst_vec: got %h required 0", vec_out[127:0]); end
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start_load(32'h40, 6'd5);
        wait_done(20, lat);
        n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL midrst_reload_latency: got %0d required 6", lat); end
        @(negedge clk);
        n_cmp++; if (vec_out !== exp_vec(32'h40, 5)) begin n_fail++; $display("FAIL midrst_reload_vec: got %h required %h", vec_out[159:0], exp_vec(32'h40, 5) >> 0); end
        n_cmp++; if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_valid: got %b required 1", vec_valid); end
    endtask

    task automatic test_wrap();
        int lat;
        start_load(32'hFFFF_FFF8, 6'd4);
        wait_done(20, lat);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL wrap_latency: got %0d required 5", lat); end
        @(negedge clk);
        n_cmp++; if (vec_out !== exp_vec(32'hFFFF_FFF8, 4)) begin n_fail++; $display("FAIL wrap_vec: got %h required %h", vec_out[127:0], exp_vec(32'hFFFF_FFF8, 4) >> 0); end
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_sb_empty: %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int lat;
        bit seen;
        stuck_after = 2;
        start_load(32'h300, 6'd8);
`ifdef MCC_VLD_TIMEOUT_EN
        wait_done(40, lat);
        n_cmp++; if (lat !== 2 + TO + 1) begin n_fail++; $display("FAIL to_latency: got %0d required %0d", lat, 2 + TO + 1); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b required 1", err); end
        @(negedge clk);
        n_cmp++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid: got %b required 0", vec_valid); end
        n_cmp++; if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL to_idle_err: busy,err=%b required 01", {busy, err}); end
        n_cmp++; if (vec_out !== exp_vec(32'h300, 2)) begin n_fail++; $display("FAIL to_vec: got %h required %h", vec_out[127:0], exp_vec(32'h300, 2) >> 0); end
        lat = 0;
        seen = 1'b0;
`else
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 300; k++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if ({busy, seen} !== 2'b10) begin n_fail++; $display("FAIL stuck_busy: busy,done_seen=%b required 10", {busy, seen}); end
        n_cmp++; if (hs_cnt !== 2) begin n_fail++; $display("FAIL stuck_handshakes: got %0d required 2", hs_cnt); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL stuck_err: got %b required 0", err); end
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
`endif
        exp_q.delete();
        stuck_after = -1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_len_zero();
        test_len_clamp();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
